// File: rtl/d16_pkg.sv
// Shared definitions for the d16 Wishbone arbiter slice.
// Holds the arbiter state enum and the address/data bus widths.
// The state encoding is chosen to match the one-hot grant vector.
package d16_pkg;

    localparam int unsigned D16_WB_AW = 16;
    localparam int unsigned D16_WB_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/d16_wb_watchdog.sv
// Bus watchdog counter for the d16 arbiter.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   clear            : synchronous clear (has priority over count_en)
//   count_en         : advance the count by one this cycle
//   expired          : count has reached TIMEOUT-1
module d16_wb_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned       CW    = $clog2(TIMEOUT);
    localparam logic [CW-1:0]     LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/d16_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single slave.
// Ports:
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_mN_cyc/we/addr/dat      : master N request (N = 0, 1)
//   o_mN_dat/ack/err          : response to master N (err = timeout abort)
//   o_s_cyc/we/addr/dat       : muxed request to the slave
//   i_s_dat, i_s_ack          : slave response
//   o_grant                   : one-hot current owner, 00 when idle
module d16_wb_arbiter
    import d16_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_m0_cyc,
    input  logic                 i_m0_we,
    input  logic [D16_WB_AW-1:0] i_m0_addr,
    input  logic [D16_WB_DW-1:0] i_m0_dat,
    output logic [D16_WB_DW-1:0] o_m0_dat,
    output logic                 o_m0_ack,
    output logic                 o_m0_err,
    input  logic                 i_m1_cyc,
    input  logic                 i_m1_we,
    input  logic [D16_WB_AW-1:0] i_m1_addr,
    input  logic [D16_WB_DW-1:0] i_m1_dat,
    output logic [D16_WB_DW-1:0] o_m1_dat,
    output logic                 o_m1_ack,
    output logic                 o_m1_err,
    output logic                 o_s_cyc,
    output logic                 o_s_we,
    output logic [D16_WB_AW-1:0] o_s_addr,
    output logic [D16_WB_DW-1:0] o_s_dat,
    input  logic [D16_WB_DW-1:0] i_s_dat,
    input  logic                 i_s_ack,
    output logic [1:0]           o_grant
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       own_cyc;
    logic       timeout;
    logic       wd_expired;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        own_cyc  = 1'b0;
        timeout  = 1'b0;
        o_s_cyc  = 1'b0;
        o_s_we   = 1'b0;
        o_s_addr = '0;
        o_s_dat  = '0;
        o_m0_dat = '0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_dat = '0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the master that did not own the bus last wins.
                if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                own_cyc  = i_m0_cyc;
                // Ack in the final watchdog cycle beats the abort.
                timeout  = i_m0_cyc && !i_s_ack && wd_expired;
                o_s_cyc  = i_m0_cyc && !timeout;
                o_s_we   = i_m0_we;
                o_s_addr = i_m0_addr;
                o_s_dat  = i_m0_dat;
                o_m0_dat = i_s_dat;
                o_m0_ack = i_s_ack;
                o_m0_err = timeout;
                if (!i_m0_cyc || timeout) state_d = IDLE;
            end
            OWN1: begin
                own_cyc  = i_m1_cyc;
                timeout  = i_m1_cyc && !i_s_ack && wd_expired;
                o_s_cyc  = i_m1_cyc && !timeout;
                o_s_we   = i_m1_we;
                o_s_addr = i_m1_addr;
                o_s_dat  = i_m1_dat;
                o_m1_dat = i_s_dat;
                o_m1_ack = i_s_ack;
                o_m1_err = timeout;
                if (!i_m1_cyc || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unique case (state_q)
            OWN0:    o_grant = 2'b01;
            OWN1:    o_grant = 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Clearing in IDLE also covers the grant edge: a new owner starts at zero.
    d16_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clear     ((state_q == IDLE) || i_s_ack || timeout),
        .count_en  ((state_q != IDLE) && own_cyc && !i_s_ack),
        .expired   (wd_expired)
    );

endmodule

// File: tb/tb_d16_wb_arbiter.sv
module tb_d16_wb_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_cyc, m0_we, m1_cyc, m1_we;
    logic [15:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
    logic [15:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_we, s_ack;
    logic [15:0] s_addr, s_wdat, s_rdat;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 = nobody), last owner, un-acked cycles so far.
    int m_owner;
    int m_last;
    int m_wait;

    always #5 clk = ~clk;

    d16_wb_arbiter #(
        .TIMEOUT (TO)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_m0_cyc  (m0_cyc),
        .i_m0_we   (m0_we),
        .i_m0_addr (m0_addr),
        .i_m0_dat  (m0_wdat),
        .o_m0_dat  (m0_rdat),
        .o_m0_ack  (m0_ack),
        .o_m0_err  (m0_err),
        .i_m1_cyc  (m1_cyc),
        .i_m1_we   (m1_we),
        .i_m1_addr (m1_addr),
        .i_m1_dat  (m1_wdat),
        .o_m1_dat  (m1_rdat),
        .o_m1_ack  (m1_ack),
        .o_m1_err  (m1_err),
        .o_s_cyc   (s_cyc),
        .o_s_we    (s_we),
        .o_s_addr  (s_addr),
        .o_s_dat   (s_wdat),
        .i_s_dat   (s_rdat),
        .i_s_ack   (s_ack),
        .o_grant   (grant)
    );

    function automatic logic [71:0] observed();
        return {grant, s_cyc, s_we, s_addr, s_wdat,
                m0_rdat, m0_ack, m0_err, m1_rdat, m1_ack, m1_err};
    endfunction

    function automatic logic owner_cyc();
        if (m_owner == 0) return m0_cyc;
        if (m_owner == 1) return m1_cyc;
        return 1'b0;
    endfunction

    function automatic logic model_timeout();
        return (m_owner >= 0) && owner_cyc() && !s_ack && (m_wait == TO - 1);
    endfunction

    function automatic logic [71:0] expected();
        logic [1:0]  g;
        logic        sc, sw, a0, a1, e0, e1, t;
        logic [15:0] sa, sd, d0, d1;
        g = 2'b00; sc = 0; sw = 0; a0 = 0; a1 = 0; e0 = 0; e1 = 0;
        sa = '0; sd = '0; d0 = '0; d1 = '0;
        t = model_timeout();
        if (reset_n && m_owner == 0) begin
            g = 2'b01; sc = m0_cyc && !t; sw = m0_we; sa = m0_addr; sd = m0_wdat;
            d0 = s_rdat; a0 = s_ack; e0 = t;
        end else if (reset_n && m_owner == 1) begin
            g = 2'b10; sc = m1_cyc && !t; sw = m1_we; sa = m1_addr; sd = m1_wdat;
            d1 = s_rdat; a1 = s_ack; e1 = t;
        end
        return {g, sc, sw, sa, sd, d0, a0, e0, d1, a1, e1};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_wait  = 0;
    endtask

    task automatic model_edge(input logic t);
        if (!reset_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (m0_cyc && m1_cyc) m_owner = 1 - m_last;
            else if (m0_cyc)      m_owner = 0;
            else if (m1_cyc)      m_owner = 1;
            if (m_owner >= 0) m_last = m_owner;
            m_wait = 0;
        end else if (!owner_cyc() || t) begin
            m_owner = -1;
            m_wait  = 0;
        end else if (s_ack) begin
            m_wait = 0;
        end else begin
            m_wait++;
        end
    endtask

    // Advance one clock: inputs stay stable across the edge, model follows.
    task automatic tick();
        logic t;
        t = model_timeout();
        @(posedge clk);
        model_edge(t);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_we = 0; m0_addr = '0; m0_wdat = '0;
        m1_cyc = 0; m1_we = 0; m1_addr = '0; m1_wdat = '0;
        s_ack = 0; s_rdat = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            m0_cyc = 1'($urandom); m1_cyc = 1'($urandom);
            m0_addr = 16'($urandom); m1_addr = 16'($urandom);
            s_ack = 1'($urandom); s_rdat = 16'($urandom);
            #1;
            checks++;
            if (observed() !== 72'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %h want 0", c, observed());
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            m1_cyc  = (c <= 3);
            m1_addr = 16'h1234;
            m1_we   = 1'b0;
            s_ack   = (c == 3);
            s_rdat  = (c == 3) ? 16'hBEEF : 16'h0000;
            #1;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL single_model cycle %0d got %h want %h", c, observed(), expected());
            end
            if (c == 1) begin
                checks++;
                if (grant !== 2'b10 || s_addr !== 16'h1234 || s_cyc !== 1'b1) begin
                    errors++;
                    $display("FAIL single_grant got g=%b addr=%h cyc=%b want g=10 addr=1234 cyc=1",
                             grant, s_addr, s_cyc);
                end
            end
            if (c == 3) begin
                checks++;
                if (m1_rdat !== 16'hBEEF || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL single_ack got dat=%h ack=%b m0ack=%b want BEEF 1 0",
                             m1_rdat, m1_ack, m0_ack);
                end
            end
            if (c == 5) begin
                checks++;
                if (grant !== 2'b00) begin
                    errors++;
                    $display("FAIL single_idle got %b want 00", grant);
                end
            end
            tick();
        end
    endtask

    task automatic test_tie_after_reset();
        logic [1:0] want [0:5];
        want = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            m0_cyc = (c < 2);
            m1_cyc = 1'b1;
            m0_addr = 16'h00A0; m1_addr = 16'h00B1;
            #1;
            checks++;
            if (grant !== want[c] || observed() !== expected()) begin
                errors++;
                $display("FAIL tie cycle %0d got g=%b vec=%h want g=%b vec=%h",
                         c, grant, observed(), want[c], expected());
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        prev = 2'b00;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) begin
                m0_cyc = (c < 2);
                m1_cyc = (c < 2);
                s_ack  = (c == 1);
                s_rdat = 16'(r * 16'h0111);
                #1;
                checks++;
                if (observed() !== expected()) begin
                    errors++;
                    $display("FAIL rr_model round %0d cycle %0d got %h want %h",
                             r, c, observed(), expected());
                end
                if (c == 1) begin
                    checks++;
                    if (grant !== ((r % 2 == 0) ? 2'b01 : 2'b10) || grant === prev) begin
                        errors++;
                        $display("FAIL rr_grant round %0d got %b want %b (prev %b)",
                                 r, grant, (r % 2 == 0) ? 2'b01 : 2'b10, prev);
                    end
                    prev = grant;
                end
                tick();
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            m0_cyc = 1'b1;
            m1_cyc = (c >= 3);
            m0_addr = 16'hC0DE;
            #1;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL timeout_model cycle %0d got %h want %h", c, observed(), expected());
            end
            checks++;
            if ((m0_err !== (c == 4)) || (c == 4 && s_cyc !== 1'b0)) begin
                errors++;
                $display("FAIL timeout_err cycle %0d got err=%b cyc=%b want err=%b",
                         c, m0_err, s_cyc, (c == 4));
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (grant !== ((c == 5) ? 2'b00 : 2'b10)) begin
                    errors++;
                    $display("FAIL timeout_regrant cycle %0d got %b want %b",
                             c, grant, (c == 5) ? 2'b00 : 2'b10);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_ack_last_cycle();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            m0_cyc = (c <= 8);
            s_ack  = (c == 4);
            s_rdat = (c == 4) ? 16'h5A5A : 16'h0000;
            #1;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL acklast_model cycle %0d got %h want %h", c, observed(), expected());
            end
            if (c == 4) begin
                checks++;
                if (m0_ack !== 1'b1 || m0_err !== 1'b0 || s_cyc !== 1'b1 || m0_rdat !== 16'h5A5A) begin
                    errors++;
                    $display("FAIL acklast_ack got ack=%b err=%b cyc=%b dat=%h want 1 0 1 5a5a",
                             m0_ack, m0_err, s_cyc, m0_rdat);
                end
            end
            if (c == 5) begin
                checks++;
                if (grant !== 2'b01) begin
                    errors++;
                    $display("FAIL acklast_hold got %b want 01", grant);
                end
            end
            if (c == 8) begin
                checks++;
                if (m0_err !== 1'b1) begin
                    errors++;
                    $display("FAIL acklast_rearm got err=%b want 1", m0_err);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_cyc = 1'b1;
        m1_addr = 16'h7777;
        tick();
        #1;
        checks++;
        if (grant !== 2'b10 || s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre got g=%b cyc=%b want 10 1", grant, s_cyc);
        end
        #1;
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if (grant !== 2'b00 || s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got g=%b cyc=%b want 00 0", grant, s_cyc);
        end
        m0_cyc = 1'b1;
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL midreset_release got %h want %h", observed(), expected());
        end
        tick();
        #1;
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL midreset_tie got %b want 01", grant);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            m0_cyc  = ($urandom_range(0, 9) < 7);
            m1_cyc  = ($urandom_range(0, 9) < 6);
            m0_we   = 1'($urandom);
            m1_we   = 1'($urandom);
            m0_addr = 16'($urandom); m0_wdat = 16'($urandom);
            m1_addr = 16'($urandom); m1_wdat = 16'($urandom);
            s_ack   = ($urandom_range(0, 3) == 0);
            s_rdat  = 16'($urandom);
            #1;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random cycle %0d got %h want %h", c, observed(), expected());
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_tie_after_reset();
        test_round_robin();
        test_timeout();
        test_ack_last_cycle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d16_wb_arbiter.md
D16_WB_ARBITER -- requirements
Module: d16_wb_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: the number of consecutive un-acked granted cycles before the bus is aborted; legal range 2..255.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have, for each master N in {0,1}, port i_mN_cyc, input, 1 bit: master N requests and holds the bus.
REQ-005 The block SHALL have, for each master N, port i_mN_we, input, 1 bit: master N write enable.
REQ-006 The block SHALL have, for each master N, port i_mN_addr, input, 16 bits: master N address.
REQ-007 The block SHALL have, for each master N, port i_mN_dat, input, 16 bits: master N write data.
REQ-008 The block SHALL have, for each master N, port o_mN_dat, output, 16 bits: read data returned to master N.
REQ-009 The block SHALL have, for each master N, port o_mN_ack, output, 1 bit: beat complete for master N.
REQ-010 The block SHALL have, for each master N, port o_mN_err, output, 1 bit: one-cycle timeout abort for master N.
REQ-011 The block SHALL have slave ports o_s_cyc (output, 1 bit), o_s_we (output, 1 bit), o_s_addr (output, 16 bits) and o_s_dat (output, 16 bits): the muxed request to the single memory slave.
REQ-012 The block SHALL have slave ports i_s_dat (input, 16 bits) and i_s_ack (input, 1 bit): the slave response.
REQ-013 The block SHALL have port o_grant, output, 2 bits: one-hot current owner; 00 means idle.

Function
REQ-014 The arbiter SHALL be a registered FSM with states IDLE, OWN0 and OWN1, plus a 1-bit register "last" holding the most recently granted master.
REQ-015 In IDLE, if only mN_cyc is high, the FSM SHALL enter OWNN on the next edge; this is the grant latency of 1 cycle.
REQ-016 In IDLE, if both requests are high, the FSM SHALL grant the master that is not "last" (round-robin).
REQ-017 "last" SHALL be updated when a grant is taken.
REQ-018 In IDLE, o_s_cyc, o_s_we, o_s_addr and o_s_dat SHALL be 0, and all acks and errs SHALL be 0.
REQ-019 In OWNN, the slave outputs SHALL follow master N's inputs combinationally.
REQ-020 In OWNN, o_mN_dat SHALL equal i_s_dat and o_mN_ack SHALL equal i_s_ack; the other master SHALL see ack=0, err=0 and dat=0.
REQ-021 A grant SHALL be held (bus lock, multi-beat) while i_mN_cyc stays high, regardless of the other master's request.
REQ-022 In OWNN, i_mN_cyc low SHALL return the FSM to IDLE on the same edge, so a handoff always passes through at least one IDLE cycle.
REQ-023 A watchdog counter SHALL count the OWNN cycles with i_mN_cyc=1 and i_s_ack=0; it SHALL clear on ack, on grant and in IDLE.
REQ-024 When the watchdog equals TIMEOUT-1 and no ack is present, the block SHALL pulse o_mN_err for one cycle, drive o_s_cyc=0 in that cycle, and enter IDLE.
REQ-025 Re-arbitration after a timeout SHALL follow REQ-015/016; a master that keeps cyc high is regranted only under that fairness rule.
REQ-026 If ack and timeout coincide, ack SHALL win: no err, counter cleared.
REQ-027 A slave ack received while in IDLE SHALL be ignored.
REQ-028 o_grant SHALL be decoded directly from the state register.

Reset
REQ-029 While i_reset_n=0, the block SHALL be asynchronously forced to state IDLE, last=1 (so m0 wins the first tie), watchdog=0, and all outputs 0.
REQ-030 A reset asserted mid-transfer SHALL drop o_s_cyc immediately, without waiting for a clock edge.
REQ-031 Reset release SHALL be synchronous to i_clk; the first grant is possible on the first edge after release.

Structure
REQ-032 Shared package d16_pkg SHALL hold the arbiter state enum (IDLE/OWN0/OWN1) and the constant D16_WB_AW=16/D16_WB_DW=16.
REQ-033 The watchdog SHALL be a sub-module d16_wb_watchdog (parameter TIMEOUT; inputs clear and count_en; output expired), with counter width $clog2(TIMEOUT).
REQ-034 The data/address mux SHALL be combinational from the registered state only; no combinational path SHALL exist from i_mN_cyc to o_grant.

Verification
REQ-035 Single request: m1_cyc=1 at cycle 0 with addr=0x1234, slave acks at cycle 3 with 0xBEEF -> o_grant=10 at cycle 1; o_m1_dat=0xBEEF and o_m1_ack=1 at cycle 3; IDLE one cycle after cyc drops.
REQ-036 Tie after reset: both cyc high at cycle 0 -> OWN0 first; when m0 drops cyc, IDLE one cycle, then OWN1.
REQ-037 Round-robin: repeated simultaneous single-beat requests -> grants alternate 0,1,0,1; neither master is granted twice in a row.
REQ-038 Timeout: OWN0 with no ack, TIMEOUT=4 -> o_m0_err pulses on the 4th granted cycle, o_s_cyc=0 in that cycle, IDLE next.
REQ-039 Ack on the last watchdog cycle -> ack delivered, no err, grant retained.
REQ-040 Reset mid-transfer: i_reset_n low between clock edges while in OWN1 -> o_s_cyc and o_grant go to 0 immediately; after release, m0 wins the first tie.
